// File: rtl/mov_sum.sv
// mov_sum: running sum of the last LEN samples of a signed stream
//   clk           clock, all logic on posedge
//   rst           asynchronous active-low reset
//   din_*         new sample x[n] (valid/ready/data)
//   din_dly_*     delayed sample x[n-LEN] from a matching data_dly
//   dout_*        registered window sum, signed, W_DOUT bits
module mov_sum #(
   parameter int LEN = 5,
   parameter int W_DIN = 16,
   localparam int W_DOUT = W_DIN + $clog2(LEN) + 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     din_valid,
   output logic                     din_ready,
   input  logic signed [W_DIN-1:0]  din_data,
   input  logic                     din_dly_valid,
   output logic                     din_dly_ready,
   input  logic signed [W_DIN-1:0]  din_dly_data,
   output logic                     dout_valid,
   input  logic                     dout_ready,
   output logic signed [W_DOUT-1:0] dout_data
);
   localparam int CW = $clog2(LEN);
   typedef enum logic {PRIME, RUN} state_t;
   state_t state, state_next;
   logic [CW-1:0] cnt, cnt_next;
   logic signed [W_DOUT-1:0] acc, acc_next, sx_din, sx_dly;
   logic can_load, fire, last;
   always_comb begin
      sx_din = {{(W_DOUT-W_DIN){din_data[W_DIN-1]}}, din_data};
      sx_dly = {{(W_DOUT-W_DIN){din_dly_data[W_DIN-1]}}, din_dly_data};
      can_load = !dout_valid || dout_ready;
      // readies are gated by rst so nothing looks acceptable while reset is held
      din_ready = (state == PRIME) ? rst && can_load : rst && din_dly_valid && can_load;
      din_dly_ready = (state == PRIME) ? 1'b0 : rst && din_valid && can_load;
      fire = din_valid && din_ready;
      acc_next = (state == PRIME) ? acc + sx_din : acc + sx_din - sx_dly;
      last = cnt == CW'(LEN - 1);
      state_next = (state == PRIME && fire && last) ? RUN : state;
      cnt_next = (state == PRIME && fire) ? (last ? '0 : cnt + 1'b1) : cnt;
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= PRIME;
         cnt        <= '0;
         acc        <= '0;
         dout_valid <= 1'b0;
         dout_data  <= '0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
         if (fire) begin
            acc        <= acc_next;
            dout_data  <= acc_next;
            dout_valid <= 1'b1;
         end else if (dout_ready) begin
            dout_valid <= 1'b0;
         end
      end
   end
endmodule
